// File: rtl/mul.sv
// mul: sequential signed fixed-point multiplier in Q(WIDTH-FBITS).FBITS format.
// It uses shift-add over magnitudes, round-half-to-even, then a sign fix-up.
// The optional MUL_SATURATE_EN macro saturates val on overflow; without it val holds its previous value.
module mul #(
  parameter int WIDTH = 32,
  parameter int FBITS = 29
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic                    ovf,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] val
);
  localparam int WIDTHU = WIDTH - 1;
  localparam int AW     = 2 * WIDTHU;
  localparam int CW     = $clog2(WIDTHU + 1);
  localparam logic [WIDTH-1:0] SMALLEST = {1'b1, {WIDTHU{1'b0}}};
  localparam logic [CW-1:0]    LAST     = CW'(WIDTHU - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_ROUND,
    S_SIGN
  } state_t;

  state_t              r_state;
  logic                r_sign;
  logic [WIDTHU-1:0]   r_au;
  logic [WIDTHU-1:0]   r_mplr;
  logic [WIDTHU-1:0]   r_q;
  logic [AW-1:0]       r_acc;
  logic [CW-1:0]       r_cnt;

  logic                w_in_sign;
  logic                w_in_smallest;
  logic [WIDTHU+1:0]   w_rnd;
  logic                w_rnd_ovf;

  function automatic logic [WIDTHU-1:0] magnitude(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] n;
    n = x[WIDTH-1] ? -x : x;
    return n[WIDTHU-1:0];
  endfunction

  // Two spare bits above the kept field catch both the truncation carry and the rounding carry.
  function automatic logic [WIDTHU+1:0] round_q(input logic [AW-1:0] acc);
    logic [AW-1:0]     sh;
    logic [WIDTHU+1:0] q;
    logic              guard;
    logic              sticky;
    sh     = acc >> FBITS;
    q      = {1'b0, sh[WIDTHU:0]};
    guard  = 1'b0;
    sticky = 1'b0;
    for (int k = 0; k < AW; k++) begin
      if (k == FBITS - 1)
        guard = acc[k];
      else if (k < FBITS - 1)
        sticky = sticky | acc[k];
    end
    if (guard && (q[0] || sticky))
      q = q + {{(WIDTHU + 1){1'b0}}, 1'b1};
    return q;
  endfunction

  function automatic logic round_ovf(input logic [AW-1:0] acc, input logic [WIDTHU+1:0] q);
    logic [AW-1:0] hi;
    hi = acc >> (FBITS + WIDTHU + 1);
    return (|hi) || (|q[WIDTHU+1:WIDTHU]);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTHU-1:0] q);
    logic [WIDTH-1:0] m;
    m = {1'b0, q};
    return (neg && (|q)) ? -m : m;
  endfunction

`ifdef MUL_SATURATE_EN
  function automatic logic [WIDTH-1:0] saturate(input logic neg);
    logic [WIDTH-1:0] m;
    m = {1'b0, {WIDTHU{1'b1}}};
    return neg ? -m : m;
  endfunction
`endif

  assign w_in_sign     = a[WIDTH-1] ^ b[WIDTH-1];
  assign w_in_smallest = ($unsigned(a) == SMALLEST) || ($unsigned(b) == SMALLEST);
  assign w_rnd         = round_q(r_acc);
  assign w_rnd_ovf     = round_ovf(r_acc, w_rnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
      val     <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_in_smallest) begin
              done  <= 1'b1;
              ovf   <= 1'b1;
              busy  <= 1'b0;
`ifdef MUL_SATURATE_EN
              valid <= 1'b1;
              val   <= saturate(w_in_sign);
`else
              valid <= 1'b0;
`endif
            end else begin
              busy    <= 1'b1;
              valid   <= 1'b0;
              ovf     <= 1'b0;
              r_state <= S_INIT;
            end
          end
        end
        S_INIT: r_state <= S_CALC;
        S_CALC: begin
          if (r_cnt == LAST)
            r_state <= S_ROUND;
        end
        S_ROUND: begin
          if (w_rnd_ovf) begin
            ovf     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
`ifdef MUL_SATURATE_EN
            valid   <= 1'b1;
            val     <= saturate(r_sign);
`else
            valid   <= 1'b0;
`endif
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          val     <= apply_sign(r_sign, r_q);
          done    <= 1'b1;
          valid   <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The datapath needs no reset: every field is reloaded before it is read in a new operation.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (start) begin
          r_sign <= w_in_sign;
          r_au   <= magnitude(a);
          r_mplr <= magnitude(b);
        end
      end
      S_INIT: begin
        r_acc <= '0;
        r_cnt <= '0;
      end
      S_CALC: begin
        if (r_mplr[0])
          r_acc <= r_acc + ({{WIDTHU{1'b0}}, r_au} << r_cnt);
        r_mplr <= r_mplr >> 1;
        r_cnt  <= r_cnt + CW'(1);
      end
      S_ROUND: r_q <= w_rnd[WIDTHU-1:0];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul.sv
// Scoreboard bench for mul: it keeps an exact-product reference model and checks each completion against it.
// The MUL_SATURATE_EN macro selects the saturating overflow expectations.
module tb_mul;
  localparam int W = 32;
  localparam int F = 29;
  localparam logic [W-1:0]  SMALL  = {1'b1, {(W-1){1'b0}}};
  localparam longint unsigned MAXMAG = (64'd1 << (W - 1)) - 64'd1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] a = '0;
  logic signed [W-1:0] b = '0;
  logic                busy, done, valid, ovf;
  logic signed [W-1:0] val;

  mul #(.WIDTH(W), .FBITS(F)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .valid(valid), .ovf(ovf), .a(a), .b(b), .val(val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] val;
    logic         valid;
    logic         ovf;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  exp_t         me;
  int           vecs = 0;
  int           errs = 0;
  int           cyc = 0;
  logic [W-1:0] model_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact signed product, then round-half-to-even on the magnitude.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t           e;
    longint         p;
    longint unsigned m, q, rem, half;
    logic           neg, ovfl;
    neg   = xa[W-1] ^ xb[W-1];
    e.lat = 34;
    e.acc = 0;
    q     = 0;
    if (xa == SMALL || xb == SMALL) begin
      ovfl  = 1'b1;
      e.lat = 0;
    end else begin
      p = longint'($signed(xa)) * longint'($signed(xb));
      m = (p < 0) ? -p : p;
      q = m >> F;
      if (F > 0) begin
        rem  = m & ((64'd1 << F) - 64'd1);
        half = 64'd1 << (F - 1);
        if (rem > half || (rem == half && q[0])) q++;
      end
      ovfl = (q > MAXMAG);
      if (ovfl) e.lat = 33;
    end
    if (ovfl) begin
      e.ovf = 1'b1;
`ifdef MUL_SATURATE_EN
      e.valid   = 1'b1;
      e.val     = neg ? W'(-MAXMAG) : W'(MAXMAG);
      model_val = e.val;
`else
      e.valid = 1'b0;
      e.val   = model_val;
`endif
    end else begin
      e.ovf     = 1'b0;
      e.valid   = 1'b1;
      e.val     = (neg && q != 0) ? W'(-q) : W'(q);
      model_val = e.val;
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t e;
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    e = model(xa, xb);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_val"}, $unsigned(val), 0);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_done: got done=1, expected no pending operation");
        end else begin
          me = sb.pop_front();
          check("val", $unsigned(val), me.val);
          check("valid", valid, me.valid);
          check("ovf", ovf, me.ovf);
          check("busy_at_done", busy, 0);
          check("latency", cyc - me.acc, me.lat);
        end
      end
    end
  end

  logic [W-1:0] da[11] = '{32'h3000_0000, 32'hD000_0000, 32'h0000_0001, 32'h0000_0003,
                           32'h0000_0001, 32'h6000_0000, 32'h8000_0000, 32'h0000_0000,
                           32'h0000_1234, 32'h7FFF_FFFF, 32'h8000_0001};
  logic [W-1:0] db[11] = '{32'h4000_0000, 32'h4000_0000, 32'h1000_0000, 32'h1000_0000,
                           32'h1000_0001, 32'h6000_0000, 32'h0000_1234, 32'hE000_0000,
                           32'h8000_0000, 32'h2000_0000, 32'h8000_0001};

  initial begin
    logic signed [W-1:0] ta, tb;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      issue(da[i], db[i]);
      wait_done();
    end

    // A start while busy must be ignored.
    issue(32'h3000_0000, 32'h4000_0000);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid", busy, 1);
    @(negedge clk);
    a = 32'h6000_0000;
    b = 32'h1000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset during CALC aborts without a done pulse.
    issue(32'h1234_5678, 32'h0765_4321);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    sb.delete();
    model_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'hD000_0000, 32'hD000_0000);
    wait_done();
    issue(32'h6000_0000, 32'h6000_0000);
    wait_done();

    for (int i = 0; i < 150; i++) begin
      ta = $urandom;
      tb = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: begin
          ta = ta >>> $urandom_range(0, 31);
          tb = tb >>> $urandom_range(0, 31);
        end
        2: ta = ta >>> $urandom_range(24, 31);
        default: begin
          ta = ta >>> $urandom_range(1, 4);
          tb = tb >>> $urandom_range(1, 4);
        end
      endcase
      if ($urandom_range(0, 30) == 0) ta = SMALL;
      issue(ta, tb);
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
